// File: rtl/mistura_planta_if.sv
// Valve/sensor link between the mixture controller (master) and the tank plant (slave).
interface mistura_planta_if;
    logic       A;
    logic       B;
    logic       R;
    logic       E;
    logic       L;
    logic       M;
    logic [6:0] C;
    logic       upd;

    modport master (output A, B, R, E, input L, M, C, upd);
    modport slave  (input A, B, R, E, output L, M, C, upd);
endinterface

// File: rtl/mistura_planta.sv
// Mixing-tank plant model: integrates volume / liquid-A once per tick and publishes L, M, C.
// Optional stratification model enabled by defining MISTURA_PLANTA_ESTRAT_EN.
module mistura_planta #(
    parameter int VW       = 10,
    parameter int VMAX     = 1000,
    parameter int V_LIM    = 900,
    parameter int V_MIN    = 100,
    parameter int FLOW     = 10,
    parameter int TICK_DIV = 64
) (
    input  logic            clk,
    input  logic            rst,
    mistura_planta_if.slave bus
);
    localparam int NW = VW + 7;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(NW);

    localparam logic [VW-1:0] VMAX_V    = VW'(VMAX);
    localparam logic [VW-1:0] VLIM_V    = VW'(V_LIM);
    localparam logic [VW-1:0] VMIN_V    = VW'(V_MIN);
    localparam logic [VW-1:0] FLOW_V    = VW'(FLOW);
    localparam logic [VW-1:0] HUNDRED_V = VW'(100);
    localparam logic [NW-1:0] HUNDRED_N = NW'(100);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(NW - 1);
    localparam logic [VW-1:0] ZERO_V    = {VW{1'b0}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        APPLY     = 3'd1,
        DRAIN_DIV = 3'd2,
        DRAIN_UPD = 3'd3,
        CONC_DIV  = 3'd4,
        PUBLISH   = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [TW-1:0]   tick_r;
    logic [VW-1:0]   v_r;
    logic [VW-1:0]   va_r;
    logic [VW-1:0]   fd_r;
    logic [NW-1:0]   quot_r;
    logic [VW-1:0]   rem_r;
    logic [VW-1:0]   divisor_r;
    logic [CW-1:0]   dcnt_r;
    logic            l_r;
    logic            m_r;
    logic [6:0]      c_r;
    logic            upd_r;

    logic [VW-1:0]   head_a_s;
    logic [VW-1:0]   add_a_s;
    logic [VW-1:0]   v1_s;
    logic [VW-1:0]   va1_s;
    logic [VW-1:0]   head_b_s;
    logic [VW-1:0]   add_b_s;
    logic [VW-1:0]   v2_s;
    logic [VW-1:0]   fd_s;
    logic            drain_s;
    logic [VW:0]     trial_s;
    logic [VW-1:0]   rem_nx_s;
    logic [NW-1:0]   quot_nx_s;
    logic            div_last_s;
    logic [VW-1:0]   da_lim_s;
    logic [VW-1:0]   v_d_s;
    logic [VW-1:0]   va_sub_s;
    logic [VW-1:0]   va_d_s;
    logic [NW-1:0]   num_drain_s;
    logic [NW-1:0]   num_conc_apply_s;
    logic [NW-1:0]   num_conc_drain_s;

`ifdef MISTURA_PLANTA_ESTRAT_EN
    logic            r_lat_r;
    logic            zero_prev_r;
`else
    logic            unused_r_s;
    assign unused_r_s = bus.R;
`endif

    // Inflow: A claims the headroom first, B gets what is left; drain length taken from V''.
    always_comb begin
        head_a_s = VMAX_V - v_r;
        if (bus.A) begin
            add_a_s = (head_a_s < FLOW_V) ? head_a_s : FLOW_V;
        end else begin
            add_a_s = ZERO_V;
        end
        v1_s     = v_r + add_a_s;
        va1_s    = va_r + add_a_s;
        head_b_s = VMAX_V - v1_s;
        if (bus.B) begin
            add_b_s = (head_b_s < FLOW_V) ? head_b_s : FLOW_V;
        end else begin
            add_b_s = ZERO_V;
        end
        v2_s    = v1_s + add_b_s;
        fd_s    = (v2_s < FLOW_V) ? v2_s : FLOW_V;
        drain_s = bus.E && (v2_s != ZERO_V);
        num_drain_s      = {{7{1'b0}}, fd_s} * {{(NW-7){1'b0}}, c_r};
        num_conc_apply_s = {{7{1'b0}}, va1_s} * HUNDRED_N;
    end

    // One restoring-divider step plus the post-drain volume bookkeeping.
    always_comb begin
        trial_s = {rem_r, quot_r[NW-1]};
        if (trial_s >= {1'b0, divisor_r}) begin
            rem_nx_s  = trial_s[VW-1:0] - divisor_r;
            quot_nx_s = {quot_r[NW-2:0], 1'b1};
        end else begin
            rem_nx_s  = trial_s[VW-1:0];
            quot_nx_s = {quot_r[NW-2:0], 1'b0};
        end
        div_last_s = (dcnt_r == DIV_LAST);
        if (quot_r < {{7{1'b0}}, va_r}) begin
            da_lim_s = quot_r[VW-1:0];
        end else begin
            da_lim_s = va_r;
        end
        v_d_s    = v_r - fd_r;
        va_sub_s = va_r - da_lim_s;
        va_d_s   = (va_sub_s < v_d_s) ? va_sub_s : v_d_s;
        num_conc_drain_s = {{7{1'b0}}, va_d_s} * HUNDRED_N;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick_r == TICK_LAST) begin
                    state_nx_s = APPLY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            APPLY: begin
                if (drain_s) begin
                    state_nx_s = DRAIN_DIV;
                end else begin
                    state_nx_s = CONC_DIV;
                end
            end
            DRAIN_DIV: begin
                if (div_last_s) begin
                    state_nx_s = DRAIN_UPD;
                end else begin
                    state_nx_s = DRAIN_DIV;
                end
            end
            DRAIN_UPD: state_nx_s = CONC_DIV;
            CONC_DIV: begin
                if ((v_r == ZERO_V) || div_last_s) begin
                    state_nx_s = PUBLISH;
                end else begin
                    state_nx_s = CONC_DIV;
                end
            end
            PUBLISH: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Tank state, shared divider and published sensor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r    <= {TW{1'b0}};
            v_r       <= ZERO_V;
            va_r      <= ZERO_V;
            fd_r      <= ZERO_V;
            quot_r    <= {NW{1'b0}};
            rem_r     <= ZERO_V;
            divisor_r <= ZERO_V;
            dcnt_r    <= {CW{1'b0}};
            l_r       <= 1'b0;
            m_r       <= 1'b0;
            c_r       <= 7'd0;
            upd_r     <= 1'b0;
`ifdef MISTURA_PLANTA_ESTRAT_EN
            r_lat_r     <= 1'b0;
            zero_prev_r <= 1'b1;
`endif
        end else begin
            upd_r <= 1'b0;
            if ((state_r == IDLE) && (tick_r != TICK_LAST)) begin
                tick_r <= tick_r + 1'b1;
            end else begin
                tick_r <= {TW{1'b0}};
            end
            case (state_r)
                APPLY: begin
                    v_r    <= v2_s;
                    va_r   <= va1_s;
                    fd_r   <= fd_s;
                    rem_r  <= ZERO_V;
                    dcnt_r <= {CW{1'b0}};
`ifdef MISTURA_PLANTA_ESTRAT_EN
                    r_lat_r <= bus.R;
`endif
                    if (drain_s) begin
                        quot_r    <= num_drain_s;
                        divisor_r <= HUNDRED_V;
                    end else begin
                        quot_r    <= num_conc_apply_s;
                        divisor_r <= v2_s;
                    end
                end
                DRAIN_DIV: begin
                    quot_r <= quot_nx_s;
                    rem_r  <= rem_nx_s;
                    dcnt_r <= dcnt_r + 1'b1;
                end
                DRAIN_UPD: begin
                    v_r       <= v_d_s;
                    va_r      <= va_d_s;
                    quot_r    <= num_conc_drain_s;
                    divisor_r <= v_d_s;
                    rem_r     <= ZERO_V;
                    dcnt_r    <= {CW{1'b0}};
                end
                CONC_DIV: begin
                    // An empty tank has no concentration: publish 0 without dividing by zero.
                    if (v_r == ZERO_V) begin
                        quot_r <= {NW{1'b0}};
                    end else begin
                        quot_r <= quot_nx_s;
                        rem_r  <= rem_nx_s;
                        dcnt_r <= dcnt_r + 1'b1;
                    end
                end
                PUBLISH: begin
                    l_r   <= (v_r >= VLIM_V);
                    m_r   <= (v_r >= VMIN_V);
                    upd_r <= 1'b1;
`ifdef MISTURA_PLANTA_ESTRAT_EN
                    if (r_lat_r || zero_prev_r) begin
                        c_r <= quot_r[6:0];
                    end else begin
                        c_r <= c_r;
                    end
                    zero_prev_r <= (v_r == ZERO_V);
`else
                    c_r <= quot_r[6:0];
`endif
                end
                default: begin
                    quot_r <= quot_r;
                end
            endcase
        end
    end

    assign bus.L   = l_r;
    assign bus.M   = m_r;
    assign bus.C   = c_r;
    assign bus.upd = upd_r;

endmodule

// File: tb/tb_mistura_planta.sv
// Directed bench for mistura_planta: hand-computed L/M/C after each plant update.
module tb_mistura_planta;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef MISTURA_PLANTA_ESTRAT_EN
    localparam int C_STRAT = 100;
`else
    localparam int C_STRAT = 90;
`endif

    always #5 clk = ~clk;

    mistura_planta_if bus ();

    mistura_planta dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_upd(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while ((bus.upd !== 1'b1) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_upd"}, {31'd0, bus.upd}, 32'd1);
    endtask

    task automatic tick(input logic a, input logic b, input logic e, input logic r, input string tag);
        bus.A = a;
        bus.B = b;
        bus.E = e;
        bus.R = r;
        wait_upd(tag);
    endtask

    task automatic check_out(input string tag, input int l, input int m, input int c);
        check({tag, "_L"}, {31'd0, bus.L}, l);
        check({tag, "_M"}, {31'd0, bus.M}, m);
        check({tag, "_C"}, {25'd0, bus.C}, c);
    endtask

    // Reset while the concentration divide of the next tick is running.
    task automatic reset_in_conc(input string tag);
        bus.A = 1'b1;
        bus.B = 1'b0;
        bus.E = 1'b0;
        bus.R = 1'b1;
        repeat (70) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_out(tag, 0, 0, 0);
        check({tag, "_upd0"}, {31'd0, bus.upd}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        bus.A = 1'b0;
        bus.B = 1'b0;
        bus.E = 1'b0;
        bus.R = 1'b1;
        repeat (2) @(negedge clk);
        check_out("rst", 0, 0, 0);
        check("rst_upd", {31'd0, bus.upd}, 32'd0);
        rst = 1'b0;

        // Inflow before drain from empty, then VA must have been clamped to V=0.
        tick(1'b1, 1'b0, 1'b1, 1'b1, "ae_empty");
        check_out("ae_empty", 0, 0, 0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, "clamp");
        check_out("clamp", 0, 0, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, "a20");
        check_out("a20", 0, 0, 50);
        reset_in_conc("rst_mid");

        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, "fill_a");
            if (i == 9) check_out("fill_a9", 0, 0, 100);
        end
        check_out("fill_a10", 0, 1, 100);

        tick(1'b0, 1'b1, 1'b0, 1'b0, "b_r0");
        check_out("b_r0", 0, 1, C_STRAT);
        tick(1'b0, 1'b0, 1'b0, 1'b1, "mix");
        check_out("mix", 0, 1, 90);
        repeat (9) tick(1'b0, 1'b1, 1'b0, 1'b1, "fill_b");
        check_out("fill_b", 0, 1, 50);

        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, "drain");
            if (i == 1)  check_out("drain1", 0, 1, 50);
            if (i == 10) check_out("drain10", 0, 1, 50);
            if (i == 11) check_out("drain11", 0, 0, 50);
        end
        check_out("drain20", 0, 0, 0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, "drain_empty");
        check_out("drain_empty", 0, 0, 0);

        for (int i = 1; i <= 44; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, "ramp");
            if (i == 1) check_out("ramp1", 0, 0, 50);
        end
        check_out("ramp880", 0, 1, 50);
        tick(1'b1, 1'b1, 1'b0, 1'b1, "ramp900");
        check_out("ramp900", 1, 1, 50);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b1, "ramp980");
        tick(1'b1, 1'b0, 1'b0, 1'b1, "a990");
        check_out("a990", 1, 1, 50);
        tick(1'b1, 1'b1, 1'b0, 1'b1, "ab_prio");
        check_out("ab_prio", 1, 1, 51);
        tick(1'b1, 1'b1, 1'b0, 1'b1, "sat_ab");
        check_out("sat_ab", 1, 1, 51);
        tick(1'b0, 1'b1, 1'b0, 1'b1, "sat_b");
        check_out("sat_b", 1, 1, 51);
        tick(1'b0, 1'b0, 1'b1, 1'b1, "drain_full");
        check_out("drain_full", 1, 1, 51);

        reset_in_conc("rst_conc");
        tick(1'b1, 1'b0, 1'b0, 1'b1, "post_rst");
        check_out("post_rst", 0, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
